// File: rtl/rsa_pkg.sv
// Shared RSA-core definitions: default widths, modexp FSM state encoding and
// the Montgomery-domain constant used to leave the domain (multiply by 1).
package rsa_pkg;

    localparam int DEF_WIDTH  = 512;
    localparam int DEF_E_BITS = 512;

    typedef enum logic [3:0] {
        S_IDLE,
        S_PRE_ISSUE,
        S_PRE_WAIT,
        S_SCAN,
        S_SQ_ISSUE,
        S_SQ_WAIT,
        S_ML_ISSUE,
        S_ML_WAIT,
        S_POST_ISSUE,
        S_POST_WAIT,
        S_FINISH
    } state_t;

    localparam logic [DEF_WIDTH-1:0] ONE = {{DEF_WIDTH-1{1'b0}}, 1'b1};

endpackage

// File: rtl/modexp_ctrl.sv
// Left-to-right binary modular exponentiation sequencer driving one Montgomery multiplier.
// Optional MODEXP_SKIP_LZ_EN adds a SCAN state that skips the exponent's leading zeros.
module modexp_ctrl
    import rsa_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int E_BITS = DEF_E_BITS
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [WIDTH-1:0]  in_x,
    input  logic [E_BITS-1:0] in_e,
    input  logic [WIDTH-1:0]  in_m,
    input  logic [WIDTH-1:0]  in_r,
    input  logic [WIDTH-1:0]  in_r2,
    output logic [WIDTH-1:0]  result,
    output logic              done,
    output logic              busy,
    output logic              mm_start,
    output logic [WIDTH-1:0]  mm_a,
    output logic [WIDTH-1:0]  mm_b,
    output logic [WIDTH-1:0]  mm_m,
    input  logic [WIDTH-1:0]  mm_result,
    input  logic              mm_done
);

    localparam int IW = (E_BITS > 1) ? $clog2(E_BITS) : 1;
    localparam logic [WIDTH-1:0] ONE_W = WIDTH'(ONE);

    state_t            state;
    logic [WIDTH-1:0]  x_q, r_q, r2_q, a_q, xt_q;
    logic [E_BITS-1:0] e_q;
    logic [IW-1:0]     idx;

    // Operands are a pure function of registered state, so they are stable
    // from the ISSUE cycle until the matching mm_done.
    always_comb begin
        mm_a = '0;
        mm_b = '0;
        case (state)
            S_PRE_ISSUE, S_PRE_WAIT: begin
                mm_a = x_q;
                mm_b = r2_q;
            end
            S_SQ_ISSUE, S_SQ_WAIT: begin
                mm_a = a_q;
                mm_b = a_q;
            end
            S_ML_ISSUE, S_ML_WAIT: begin
                mm_a = a_q;
                mm_b = xt_q;
            end
            S_POST_ISSUE, S_POST_WAIT: begin
                mm_a = a_q;
                mm_b = ONE_W;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= S_IDLE;
            result   <= '0;
            done     <= 1'b0;
            busy     <= 1'b0;
            mm_start <= 1'b0;
            mm_m     <= '0;
            x_q      <= '0;
            r_q      <= '0;
            r2_q     <= '0;
            a_q      <= '0;
            xt_q     <= '0;
            e_q      <= '0;
            idx      <= '0;
        end else begin
            mm_start <= 1'b0;
            done     <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    x_q      <= in_x;
                    e_q      <= in_e;
                    mm_m     <= in_m;
                    r_q      <= in_r;
                    r2_q     <= in_r2;
                    idx      <= IW'(E_BITS - 1);
                    busy     <= 1'b1;
                    mm_start <= 1'b1;
                    state    <= S_PRE_ISSUE;
                end
                S_PRE_ISSUE: state <= S_PRE_WAIT;
                S_PRE_WAIT: if (mm_done) begin
                    xt_q <= mm_result;
                    a_q  <= r_q;
`ifdef MODEXP_SKIP_LZ_EN
                    state <= S_SCAN;
`else
                    mm_start <= 1'b1;
                    state    <= S_SQ_ISSUE;
`endif
                end
`ifdef MODEXP_SKIP_LZ_EN
                S_SCAN: begin
                    if (!e_q[idx] && idx != '0) begin
                        idx <= idx - IW'(1);
                    end else begin
                        mm_start <= 1'b1;
                        state    <= S_SQ_ISSUE;
                    end
                end
`endif
                S_SQ_ISSUE: state <= S_SQ_WAIT;
                S_SQ_WAIT: if (mm_done) begin
                    a_q      <= mm_result;
                    mm_start <= 1'b1;
                    if (e_q[idx]) begin
                        state <= S_ML_ISSUE;
                    end else if (idx == '0) begin
                        state <= S_POST_ISSUE;
                    end else begin
                        idx   <= idx - IW'(1);
                        state <= S_SQ_ISSUE;
                    end
                end
                S_ML_ISSUE: state <= S_ML_WAIT;
                S_ML_WAIT: if (mm_done) begin
                    a_q      <= mm_result;
                    mm_start <= 1'b1;
                    if (idx == '0) begin
                        state <= S_POST_ISSUE;
                    end else begin
                        idx   <= idx - IW'(1);
                        state <= S_SQ_ISSUE;
                    end
                end
                S_POST_ISSUE: state <= S_POST_WAIT;
                S_POST_WAIT: if (mm_done) begin
                    result <= mm_result;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= S_FINISH;
                end
                S_FINISH: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_modexp_ctrl.sv
// Bench for modexp_ctrl paired with a behavioural Montgomery multiplier of variable latency.
module tb_modexp_ctrl;

    localparam int W = 512;
    localparam int E = 16;
    localparam int LIMIT = 20000;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic start = 1'b0;
    logic [W-1:0] in_x, in_m, in_r, in_r2;
    logic [E-1:0] in_e;
    logic [W-1:0] result, mm_a, mm_b, mm_m, mm_result;
    logic done, busy, mm_start, mm_done;
    logic mdl_done = 1'b0;
    logic inj_done = 1'b0;

    assign mm_done = mdl_done | inj_done;

    always #5 clk = ~clk;

    modexp_ctrl #(.WIDTH(W), .E_BITS(E)) dut (
        .clk(clk), .resetn(resetn), .start(start),
        .in_x(in_x), .in_e(in_e), .in_m(in_m), .in_r(in_r), .in_r2(in_r2),
        .result(result), .done(done), .busy(busy),
        .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m),
        .mm_result(mm_result), .mm_done(mm_done)
    );

    // a*b*2^-W mod m, bit-serial REDC
    function automatic logic [W-1:0] mont(input logic [W-1:0] a, b, m);
        logic [W+1:0] t;
        t = '0;
        for (int i = 0; i < W; i++) begin
            if (a[i]) t = t + {2'b00, b};
            if (t[0]) t = t + {2'b00, m};
            t = t >> 1;
        end
        if (t >= {2'b00, m}) t = t - {2'b00, m};
        return t[W-1:0];
    endfunction

    function automatic logic [W-1:0] golden(input logic [W-1:0] x, input logic [E-1:0] e,
                                            input logic [W-1:0] m);
        logic [2*W-1:0] r, mw, xw;
        mw = {{W{1'b0}}, m};
        xw = {{W{1'b0}}, x};
        r  = (2*W)'(1);
        for (int i = E - 1; i >= 0; i--) begin
            r = (r * r) % mw;
            if (e[i]) r = (r * xw) % mw;
        end
        return r[W-1:0];
    endfunction

    function automatic int msb_k(input logic [E-1:0] e);
        int k = 0;
        for (int i = 0; i < E; i++) if (e[i]) k = i;
        return k;
    endfunction

    function automatic int exp_mm(input logic [E-1:0] e);
`ifdef MODEXP_SKIP_LZ_EN
        return 2 + msb_k(e) + 1 + $countones(e);
`else
        return 2 + E + $countones(e);
`endif
    endfunction

    function automatic int exp_cyc(input logic [E-1:0] e, input int l);
`ifdef MODEXP_SKIP_LZ_EN
        return exp_mm(e) * (l + 1) + 2 + (E - msb_k(e));
`else
        return exp_mm(e) * (l + 1) + 2;
`endif
    endfunction

    function automatic logic [W-1:0] rnd_w();
        logic [W-1:0] v;
        for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
        v[W-1] = 1'b0;
        return v;
    endfunction

    // multiplier model: mm_done is high L cycles after the mm_start cycle
    int cnt = 0;
    int lat_lo = 5, lat_hi = 5;
    int lat;
    always @(posedge clk) begin
        if (!resetn) begin
            mdl_done  <= 1'b0;
            cnt       <= 0;
            mm_result <= '0;
        end else begin
            mdl_done <= 1'b0;
            if (mm_start) begin
                lat = $urandom_range(lat_hi, lat_lo);
                mm_result <= mont(mm_a, mm_b, mm_m);
                if (lat <= 1) mdl_done <= 1'b1;
                else cnt <= lat - 1;
            end else if (cnt != 0) begin
                cnt <= cnt - 1;
                if (cnt == 1) mdl_done <= 1'b1;
            end
        end
    end

    int n_mm = 0, n_done = 0, viol = 0;
    always @(negedge clk) begin
        if (resetn) begin
            if (mm_start) n_mm++;
            if (done) n_done++;
            if (mm_start && (cnt != 0 || mm_done)) viol++;
        end
    end

    int n_chk = 0, n_err = 0;
    logic [W-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] expv);
        n_chk++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, expv);
        end
    endtask

    // called at a negedge; hold keeps start high until done is seen
    task automatic run(input logic [W-1:0] x, input logic [E-1:0] e, input logic [W-1:0] expv,
                       input int lo, input int hi, input logic hold);
        int c, mm0, d0, blow;
        lat_lo = lo;
        lat_hi = hi;
        in_x = x;
        in_e = e;
        exp_q.push_back(expv);
        mm0 = n_mm;
        d0 = n_done;
        blow = 0;
        start = 1'b1;
        c = 1;
        @(negedge clk);
        c++;
        if (!hold) start = 1'b0;
        chk("busy_on", W'(busy), W'(1));
        while (!done && c < LIMIT) begin
            if (!busy) blow++;
            @(negedge clk);
            c++;
        end
        start = 1'b0;
        chk("done_seen", W'(done), W'(1));
        chk("busy_at_done", W'(busy), W'(0));
        chk("busy_hold", W'(blow), W'(0));
        chk("result", result, exp_q.pop_front());
        if (lo == hi) chk("latency", W'(c), W'(exp_cyc(e, lo)));
        repeat (4) @(negedge clk);
        chk("mm_starts", W'(n_mm - mm0), W'(exp_mm(e)));
        chk("one_run", W'(n_done - d0), W'(1));
        chk("idle_after", W'(busy), W'(0));
    endtask

    initial begin
        logic [2*W-1:0] mw, rr;
        logic [W-1:0] x;
        logic [E-1:0] e;
        int k, mm0, d0;

        in_m = '1 - W'(568);
        mw = {{W{1'b0}}, in_m};
        rr = ((2*W)'(1) << W) % mw;
        in_r = rr[W-1:0];
        rr = (rr * rr) % mw;
        in_r2 = rr[W-1:0];
        in_x = '0;
        in_e = '0;

        repeat (3) @(negedge clk);
        chk("rst_result", result, '0);
        chk("rst_ctl", W'({done, busy, mm_start}), W'(0));
        chk("rst_ops", mm_a | mm_b | mm_m, '0);
        resetn = 1'b1;
        @(negedge clk);

        run(W'(2), 16'h0000, W'(1), 5, 5, 1'b0);
        run(W'(3), 16'h0005, W'(243), 5, 5, 1'b0);
        run(W'(2), 16'h0001, W'(2), 5, 5, 1'b0);
        run(W'(7), 16'h8000, golden(W'(7), 16'h8000, in_m), 1, 1, 1'b0);

        for (int t = 0; t < 3; t++) begin
            x = rnd_w();
            e = E'($urandom);
            run(x, e, golden(x, e, in_m), 3, 40, 1'b0);
        end

        // stray mm_done while idle must be ignored
        d0 = n_done;
        inj_done = 1'b1;
        @(negedge clk);
        inj_done = 1'b0;
        repeat (2) @(negedge clk);
        chk("stray_done", W'({done, busy, n_done - d0}), W'(0));

        // reset in the middle of the first squaring wait
        lat_lo = 10;
        lat_hi = 10;
        in_x = W'(7);
        in_e = 16'hFFFF;
        mm0 = n_mm;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (n_mm < mm0 + 2 && k < LIMIT) begin
            @(negedge clk);
            k++;
        end
        chk("reach_sq", W'(n_mm - mm0), W'(2));
        repeat (3) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        chk("abort_result", result, '0);
        chk("abort_ctl", W'({done, busy, mm_start}), W'(0));
        chk("abort_ops", mm_a | mm_b | mm_m, '0);
        resetn = 1'b1;
        @(negedge clk);
        run(W'(5), 16'h0003, W'(125), 6, 6, 1'b0);

        for (int t = 0; t < 2; t++) begin
            x = rnd_w();
            e = E'($urandom);
            run(x, e, golden(x, e, in_m), 3, 40, 1'b1);
        end

        chk("protocol", W'(viol), W'(0));
        chk("sb_empty", W'(exp_q.size()), W'(0));
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
